// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs decoded instruction fields back into a 16-bit instruction word using
//   the CPU decoder's bit layout. Encoded words are queued in a small FIFO and
//   emitted together with the program address they belong to. The address
//   counter always points at the FIFO head, so reloading it re-bases every
//   pending word. Tuples that cannot be encoded are consumed, dropped, flagged
//   on err_pulse and counted in a saturating err_count.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high; valid must not depend on ready, and payload is only
//   meaningful while valid is high.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   field tuple handshake (in_ready = FIFO not full)
//   in_group..in_pcbj   decoded fields: group, operator, regs, imm, offset
//   out_valid/out_ready FIFO head handshake
//   out_word, out_addr  head instruction word and its program address
//   addr_load, addr_in  reload the address counter (wins over pop increment)
//   err_pulse           one-cycle flag after an unencodable tuple is taken
//   err_count           saturating count of rejected tuples
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int                DEPTH  = 2,
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_group,
    input  logic [3:0]        in_operator,
    input  logic [3:0]        in_rg1,
    input  logic [3:0]        in_rg2,
    input  logic [1:0]        in_erg1,
    input  logic [1:0]        in_erg2,
    input  logic [7:0]        in_val,
    input  logic [8:0]        in_pcbj,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    // Group and operator codes shared with the CPU decoder (cpu_data.v).
    localparam logic [3:0] GROUP_MATH_CONSTANT = 4'h0;
    localparam logic [3:0] GROUP_BRANCH_JUMPS  = 4'h1;
    localparam logic [3:0] GROUP_MATH_REG      = 4'h2;
    localparam logic [3:0] GROUP_MATH_EREG     = 4'h3;
    localparam logic [3:0] GROUP_SINGLE_REG    = 4'h4;
    localparam logic [3:0] GROUP_STACK         = 4'h5;
    localparam logic [3:0] GROUP_REG_MEMORY    = 4'h6;
    localparam logic [3:0] GROUP_EXTENDED      = 4'h7;
    localparam logic [3:0] GROUP_OTHERS        = 4'h8;
    localparam logic [3:0] GROUP_RETURN        = 4'h9;
    localparam logic [3:0] OP_PUSH             = 4'h0;
    localparam logic [3:0] OP_POP              = 4'h1;
    localparam logic [3:0] OP_RET              = 4'h0;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [15:0]       enc_word;
    logic              enc_err;
    logic              accept;
    logic              push;
    logic              pop;
    logic [15:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              err_q, err_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Field packing; the low-order prefix bits distinguish the groups.
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (in_group)
            GROUP_MATH_CONSTANT: begin
                enc_word = {in_val, in_rg1, in_operator};
                enc_err  = (in_operator[1:0] == 2'b11);
            end
            GROUP_BRANCH_JUMPS: enc_word = {in_pcbj, in_operator, 3'b011};
            GROUP_MATH_REG:     enc_word = {in_rg2, in_rg1, in_operator, 4'b0111};
            GROUP_MATH_EREG:    enc_word = {2'b00, in_erg2, 1'b0, in_erg1, in_operator, 5'b01111};
            GROUP_SINGLE_REG: begin
                enc_word = {2'b00, in_rg1, in_operator, 6'b011111};
                enc_err  = (in_operator == OP_PUSH) || (in_operator == OP_POP);
            end
            GROUP_STACK: begin
                enc_word = {2'b00, in_rg1, in_operator, 6'b011111};
                enc_err  = !((in_operator == OP_PUSH) || (in_operator == OP_POP));
            end
            GROUP_REG_MEMORY: begin
                enc_word = {6'b000000, in_operator[2:0], 7'b0111111};
                enc_err  = in_operator[3];
            end
            GROUP_EXTENDED: enc_word = {4'b0000, in_operator, 8'h7F};
            GROUP_OTHERS: begin
                enc_word = {4'b0000, in_operator, 8'hFF};
                enc_err  = (in_operator != OP_RET);
            end
            GROUP_RETURN: begin
                enc_word = {4'b0000, in_operator, 8'hFF};
                enc_err  = (in_operator == OP_RET);
            end
            default: enc_err = 1'b1;
        endcase
    end

    // in_ready looks only at the registered count; a pop in the same cycle
    // does not open a slot until the next cycle.
    assign in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !enc_err;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        err_d     = accept && enc_err;
        if (push) wr_d = ptr_inc(wr_q);
        if (pop)  rd_d = ptr_inc(rd_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Load has priority: the head word takes the new address directly.
        if (addr_load)  addr_d = addr_in;
        else if (pop)   addr_d = addr_q + 1'b1;
        if (accept && enc_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            addr_q    <= BASE;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: out_word is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_q] <= enc_word;
    end

    assign out_word  = out_valid ? mem_q[rd_q] : 16'h0000;
    assign out_addr  = addr_q;
    assign err_pulse = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder (DEPTH=2, ADDR_W=16, BASE=0). Inputs are
//   driven on the falling edge and outputs are sampled on the falling edge,
//   so every rising edge between two steps is one registered transfer.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam logic [3:0] G_MC  = 4'h0;
    localparam logic [3:0] G_BR  = 4'h1;
    localparam logic [3:0] G_MR  = 4'h2;
    localparam logic [3:0] G_ME  = 4'h3;
    localparam logic [3:0] G_SR  = 4'h4;
    localparam logic [3:0] G_ST  = 4'h5;
    localparam logic [3:0] G_RM  = 4'h6;
    localparam logic [3:0] G_EX  = 4'h7;
    localparam logic [3:0] G_OT  = 4'h8;
    localparam logic [3:0] G_RT  = 4'h9;
    localparam logic [3:0] G_BAD = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_group, in_operator, in_rg1, in_rg2;
    logic [1:0]  in_erg1, in_erg2;
    logic [7:0]  in_val;
    logic [8:0]  in_pcbj;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic [15:0] out_addr;
    logic        addr_load;
    logic [15:0] addr_in;
    logic        err_pulse;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.DEPTH(2), .ADDR_W(16), .BASE(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_group(in_group), .in_operator(in_operator),
        .in_rg1(in_rg1), .in_rg2(in_rg2), .in_erg1(in_erg1), .in_erg2(in_erg2),
        .in_val(in_val), .in_pcbj(in_pcbj),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr),
        .addr_load(addr_load), .addr_in(addr_in),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] g, input logic [3:0] op,
                         input logic [3:0] rg1, input logic [3:0] rg2);
        in_valid    = 1'b1;
        in_group    = g;
        in_operator = op;
        in_rg1      = rg1;
        in_rg2      = rg2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        addr_load = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_word !== 16'h0000) begin bad++; $display("FAIL reset_out_word got=%h exp=0000", out_word); end
        total++; if (out_addr !== 16'h0000) begin bad++; $display("FAIL reset_out_addr got=%h exp=0000", out_addr); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
        total++; if (err_count !== 8'h00) begin bad++; $display("FAIL reset_err_count got=%h exp=00", err_count); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        in_val = 8'hA5;
        drive(G_MC, 4'h4, 4'h3, 4'h0);
        step();
        idle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_word !== 16'hA534) begin bad++; $display("FAIL single_word got=%h exp=A534", out_word); end
        total++; if (out_addr !== 16'h0000) begin bad++; $display("FAIL single_addr got=%h exp=0000", out_addr); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
        total++; if (out_addr !== 16'h0001) begin bad++; $display("FAIL single_addr_inc got=%h exp=0001", out_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        in_pcbj = 9'h1FF;
        in_erg1 = 2'd1;
        in_erg2 = 2'd2;
        drive(G_BR, 4'h2, 4'h0, 4'h0);
        step();
        total++; if (out_word !== 16'hFF93 || out_addr !== 16'h0000) begin bad++; $display("FAIL stream_branch got=%h@%h exp=FF93@0000", out_word, out_addr); end
        drive(G_MR, 4'hC, 4'h5, 4'hA);
        step();
        total++; if (out_word !== 16'hA5C7 || out_addr !== 16'h0001) begin bad++; $display("FAIL stream_mreg got=%h@%h exp=A5C7@0001", out_word, out_addr); end
        drive(G_ME, 4'h3, 4'h0, 4'h0);
        step();
        idle();
        total++; if (out_word !== 16'h226F || out_addr !== 16'h0002) begin bad++; $display("FAIL stream_ereg got=%h@%h exp=226F@0002", out_word, out_addr); end
        step();
        total++; if (out_valid !== 1'b0 || out_addr !== 16'h0003) begin bad++; $display("FAIL stream_end got=%b@%h exp=0@0003", out_valid, out_addr); end
    endtask

    task automatic test_other_groups();
        logic [3:0]  grp [6];
        logic [3:0]  ops [6];
        logic [15:0] exp [6];
        grp = '{G_SR, G_ST, G_RM, G_EX, G_OT, G_RT};
        ops = '{4'h4, 4'h0, 4'h5, 4'h5, 4'h0, 4'h2};
        exp = '{16'h0D1F, 16'h0C1F, 16'h02BF, 16'h057F, 16'h00FF, 16'h02FF};
        do_reset();
        out_ready = 1'b1;
        in_val  = 8'hA5;
        in_pcbj = 9'h1FF;
        for (int i = 0; i < 6; i++) begin
            drive(grp[i], ops[i], 4'h3, 4'hA);
            step();
            total++;
            if (out_valid !== 1'b1 || out_word !== exp[i] || err_pulse !== 1'b0) begin
                bad++;
                $display("FAIL group_%0d got v=%b w=%h e=%b exp v=1 w=%h e=0", i, out_valid, out_word, err_pulse, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_errors();
        logic [3:0] grp [8];
        logic [3:0] ops [8];
        grp = '{G_MC, G_ST, G_BAD, G_SR, G_RM, G_OT, G_RT, 4'hA};
        ops = '{4'h3, 4'h5, 4'h0, 4'h1, 4'h8, 4'h2, 4'h0, 4'h0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(grp[i], ops[i], 4'h3, 4'hA);
            step();
            total++;
            if (err_pulse !== 1'b1 || out_valid !== 1'b0 || err_count !== 8'(i + 1)) begin
                bad++;
                $display("FAIL err_%0d got p=%b v=%b c=%h exp p=1 v=0 c=%h", i, err_pulse, out_valid, err_count, 8'(i + 1));
            end
        end
        idle();
        step();
        total++; if (err_pulse !== 1'b0 || err_count !== 8'h08) begin bad++; $display("FAIL err_settle got p=%b c=%h exp p=0 c=08", err_pulse, err_count); end
        drive(G_BAD, 4'h0, 4'h0, 4'h0);
        repeat (300) step();
        idle();
        step();
        total++; if (err_count !== 8'hFF) begin bad++; $display("FAIL err_saturate got=%h exp=FF", err_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL err_no_output got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        drive(G_MR, 4'h3, 4'h2, 4'h1);
        step();
        total++; if (in_ready !== 1'b1 || out_word !== 16'h1237) begin bad++; $display("FAIL b2b_first got r=%b w=%h exp r=1 w=1237", in_ready, out_word); end
        drive(G_MR, 4'h6, 4'h5, 4'h4);
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
        drive(G_MR, 4'hA, 4'h9, 4'h8);
        step();
        step();
        total++; if (out_word !== 16'h1237 || out_addr !== 16'h0000 || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold got w=%h a=%h r=%b exp w=1237 a=0000 r=0", out_word, out_addr, in_ready); end
        out_ready = 1'b1;
        step();
        total++; if (out_word !== 16'h4567 || out_addr !== 16'h0001) begin bad++; $display("FAIL b2b_second got=%h@%h exp=4567@0001", out_word, out_addr); end
        step();
        idle();
        total++; if (out_word !== 16'h89A7 || out_addr !== 16'h0002) begin bad++; $display("FAIL b2b_third got=%h@%h exp=89A7@0002", out_word, out_addr); end
        step();
        total++; if (out_valid !== 1'b0 || out_addr !== 16'h0003) begin bad++; $display("FAIL b2b_drained got=%b@%h exp=0@0003", out_valid, out_addr); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_addr();
        do_reset();
        out_ready = 1'b0;
        addr_load = 1'b1;
        addr_in   = 16'hFFFF;
        step();
        addr_load = 1'b0;
        total++; if (out_addr !== 16'hFFFF) begin bad++; $display("FAIL addr_load got=%h exp=FFFF", out_addr); end
        drive(G_EX, 4'h1, 4'h0, 4'h0);
        step();
        drive(G_EX, 4'h2, 4'h0, 4'h0);
        step();
        idle();
        total++; if (out_word !== 16'h017F || out_addr !== 16'hFFFF) begin bad++; $display("FAIL addr_head got=%h@%h exp=017F@FFFF", out_word, out_addr); end
        out_ready = 1'b1;
        step();
        total++; if (out_word !== 16'h027F || out_addr !== 16'h0000) begin bad++; $display("FAIL addr_wrap got=%h@%h exp=027F@0000", out_word, out_addr); end
        addr_load = 1'b1;
        addr_in   = 16'h1234;
        drive(G_EX, 4'h3, 4'h0, 4'h0);
        step();
        addr_load = 1'b0;
        idle();
        total++; if (out_valid !== 1'b1 || out_word !== 16'h037F || out_addr !== 16'h1234) begin bad++; $display("FAIL addr_load_wins got v=%b %h@%h exp v=1 037F@1234", out_valid, out_word, out_addr); end
        step();
        total++; if (out_valid !== 1'b0 || out_addr !== 16'h1235) begin bad++; $display("FAIL addr_after_load got=%b@%h exp=0@1235", out_valid, out_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        drive(G_BAD, 4'h0, 4'h0, 4'h0);
        step();
        out_ready = 1'b0;
        in_val = 8'hA5;
        drive(G_MC, 4'h4, 4'h3, 4'h0);
        step();
        step();
        total++; if (err_count !== 8'h01 || out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_setup got c=%h v=%b r=%b exp c=01 v=1 r=0", err_count, out_valid, in_ready); end
        rst_n = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || out_addr !== 16'h0000 || err_count !== 8'h00) begin bad++; $display("FAIL mid_reset got v=%b a=%h c=%h exp v=0 a=0000 c=00", out_valid, out_addr, err_count); end
        total++; if (in_ready !== 1'b1 || out_word !== 16'h0000 || err_pulse !== 1'b0) begin bad++; $display("FAIL mid_reset_misc got r=%b w=%h p=%b exp r=1 w=0000 p=0", in_ready, out_word, err_pulse); end
        rst_n = 1'b1;
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_quiet_%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_group    = 4'h0;
        in_operator = 4'h0;
        in_rg1      = 4'h0;
        in_rg2      = 4'h0;
        in_erg1     = 2'd0;
        in_erg2     = 2'd0;
        in_val      = 8'h00;
        in_pcbj     = 9'h000;
        out_ready   = 1'b0;
        addr_load   = 1'b0;
        addr_in     = 16'h0000;
        test_reset();
        test_single();
        test_stream();
        test_other_groups();
        test_errors();
        test_back_to_back();
        test_addr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
